// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-through, no-write-allocate data cache.
// Define DCACHE_STATS_EN to build the hit/miss statistics counters.
module dcache_ctrl #(
  parameter int INDEX_BITS = 4,
  parameter int MEM_WAIT   = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         cpu_read,
  input  logic         cpu_write,
  input  logic [31:0]  cpu_address,
  input  logic [31:0]  cpu_write_data,
  output logic [31:0]  cpu_read_data,
  output logic         cpu_ready,
  output logic         mem_write,
  output logic [31:0]  mem_address,
  output logic [31:0]  mem_write_data,
  input  logic [511:0] mem_block_data,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count
);
  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 26 - INDEX_BITS;
  localparam logic [3:0] WAIT_INIT = 4'(MEM_WAIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WRITE
  } state_t;

  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q [LINES];
  logic [31:0] data_q [LINES][16];

  logic [3:0] offset;
  logic [INDEX_BITS-1:0] index;
  logic [TAG_W-1:0] tag;
  logic hit;
  logic rd_req;
  logic fill_done;
  logic wr_hit;
  logic unused_bits;

  assign offset = cpu_address[5:2];
  assign index = cpu_address[6 +: INDEX_BITS];
  assign tag = cpu_address[31 -: TAG_W];
  assign hit = valid_q[index] && (tag_q[index] == tag);
  assign rd_req = cpu_read & ~cpu_write;
  assign cpu_read_data = data_q[index][offset];
  assign mem_write_data = cpu_write_data;
  assign unused_bits = ^cpu_address[1:0];

  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    cpu_ready = 1'b0;
    mem_write = 1'b0;
    mem_address = cpu_address;
    fill_done = 1'b0;
    wr_hit = 1'b0;
    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          cpu_write: begin
            state_d = WRITE;
            cnt_d = WAIT_INIT;
            wr_hit = hit;
          end
          rd_req && hit: begin
            cpu_ready = 1'b1;
          end
          rd_req && !hit: begin
            state_d = FILL;
            cnt_d = WAIT_INIT;
          end
          default: begin
            cpu_ready = 1'b1;
          end
        endcase
      end
      FILL: begin
        mem_address = {cpu_address[31:6], 6'b0};
        if (cnt_q == 4'd0) begin
          fill_done = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      WRITE: begin
        mem_write = 1'b1;
        if (cnt_q == 4'd0) begin
          cpu_ready = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      if (fill_done) begin
        valid_q[index] <= 1'b1;
      end
    end
  end

  // Tag and data arrays carry no reset; valid bits guard them.
  always_ff @(posedge clk) begin
    if (fill_done) begin
      tag_q[index] <= tag;
      for (int k = 0; k < 16; k++) begin
        data_q[index][k] <= mem_block_data[32*k +: 32];
      end
    end else if (wr_hit) begin
      data_q[index][offset] <= cpu_write_data;
    end
  end

`ifdef DCACHE_STATS_EN
  logic just_filled_q;
  logic [31:0] hit_q;
  logic [31:0] miss_q;

  // The completion cycle right after a fill belongs to the miss.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      just_filled_q <= 1'b0;
      hit_q <= '0;
      miss_q <= '0;
    end else begin
      just_filled_q <= fill_done;
      if (state_q == IDLE && rd_req && hit && !just_filled_q) begin
        hit_q <= hit_q + 32'd1;
      end
      if (state_q == IDLE && rd_req && !hit) begin
        miss_q <= miss_q + 32'd1;
      end
    end
  end

  assign hit_count = hit_q;
  assign miss_count = miss_q;
`else
  assign hit_count = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: randomized and directed checks of dcache_ctrl
// against a block-level cache model and a behavioural memory.
module tb_dcache_ctrl;
  localparam int MW = 4;
`ifdef DCACHE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic cpu_read = 1'b0;
  logic cpu_write = 1'b0;
  logic [31:0] cpu_address = '0;
  logic [31:0] cpu_write_data = '0;
  logic [31:0] cpu_read_data;
  logic cpu_ready;
  logic mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [511:0] mem_block_data = '0;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int tests = 0;
  int failed = 0;
  int unsigned exp_hit = 0;
  int unsigned exp_miss = 0;

  logic [31:0] mem [int unsigned];
  bit mvalid [16];
  logic [31:0] mblk [16];

  dcache_ctrl dut (
    .clk(clk),
    .reset_n(reset_n),
    .cpu_read(cpu_read),
    .cpu_write(cpu_write),
    .cpu_address(cpu_address),
    .cpu_write_data(cpu_write_data),
    .cpu_read_data(cpu_read_data),
    .cpu_ready(cpu_ready),
    .mem_write(mem_write),
    .mem_address(mem_address),
    .mem_write_data(mem_write_data),
    .mem_block_data(mem_block_data),
    .hit_count(hit_count),
    .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    int unsigned key;
    key = a & ~32'h3;
    if (mem.exists(key)) return mem[key];
    return (a >> 2) + 32'h0000_00F0;
  endfunction

  always @(negedge clk) begin
    if (mem_write) mem[mem_address & ~32'h3] = mem_write_data;
    for (int k = 0; k < 16; k++) begin
      mem_block_data[32*k +: 32] = mem_rd({mem_address[31:6], 6'b0} + 32'(4 * k));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mvalid[i] = 1'b0;
    exp_hit = 0;
    exp_miss = 0;
  endtask

  // Called at posedge+1; returns once the request has completed.
  task automatic cpu_op(input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rdata,
                        output int stall, output int mw, output bit err);
    logic [31:0] base;
    bit done;
    base = {a[31:6], 6'b0};
    stall = 0;
    mw = 0;
    err = 1'b0;
    done = 1'b0;
    rdata = '0;
    cpu_read = rd;
    cpu_write = wr;
    cpu_address = a;
    cpu_write_data = wd;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (mem_write) mw++;
      if (wr) begin
        if (mem_address !== a || mem_write_data !== wd) err = 1'b1;
      end else if (i > 0 && !cpu_ready) begin
        if (mem_address !== base) err = 1'b1;
      end else if (mem_address !== a) begin
        err = 1'b1;
      end
      if (cpu_ready) begin
        rdata = cpu_read_data;
        done = 1'b1;
      end else begin
        stall++;
      end
    end
    if (!done) err = 1'b1;
    @(posedge clk);
    #1;
    cpu_read = 1'b0;
    cpu_write = 1'b0;
  endtask

  task automatic test_reset();
    cpu_address = 32'h0000_1234;
    #1;
    tests++;
    if (mem_write !== 1'b0) begin
      failed++;
      $display("FAIL reset_mem_write_during: got %b exp 0", mem_write);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if (cpu_ready !== 1'b1 || mem_write !== 1'b0) begin
      failed++;
      $display("FAIL reset_idle: ready %b mem_write %b exp 1 0", cpu_ready, mem_write);
    end
    tests++;
    if (mem_address !== cpu_address) begin
      failed++;
      $display("FAIL reset_mem_address: got %h exp %h", mem_address, cpu_address);
    end
    tests++;
    if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
      failed++;
      $display("FAIL reset_counters: hit %0d miss %0d exp 0 0", hit_count, miss_count);
    end
  endtask

  task automatic test_directed();
    logic [31:0] d;
    int st;
    int mw;
    bit err;
    cpu_op(1'b1, 1'b0, 32'h40, 32'h0, d, st, mw, err);
    tests++;
    if (st !== MW + 1 || d !== 32'h100 || err || mw !== 0) begin
      failed++;
      $display("FAIL first_miss: stall %0d data %h err %b mw %0d exp 5 100 0 0", st, d, err, mw);
    end
    tests++;
    if (miss_count !== (STATS ? 32'd1 : 32'd0) || hit_count !== 32'd0) begin
      failed++;
      $display("FAIL first_miss_count: miss %0d hit %0d", miss_count, hit_count);
    end
    cpu_op(1'b1, 1'b0, 32'h44, 32'h0, d, st, mw, err);
    tests++;
    if (st !== 0 || d !== 32'h101 || err) begin
      failed++;
      $display("FAIL hit_0x44: stall %0d data %h err %b exp 0 101 0", st, d, err);
    end
    tests++;
    if (hit_count !== (STATS ? 32'd1 : 32'd0)) begin
      failed++;
      $display("FAIL hit_count_1: got %0d", hit_count);
    end
    cpu_op(1'b0, 1'b1, 32'h48, 32'hDEADBEEF, d, st, mw, err);
    tests++;
    if (mw !== MW || st !== MW || err) begin
      failed++;
      $display("FAIL write_0x48: mw %0d stall %0d err %b exp 4 4 0", mw, st, err);
    end
    cpu_op(1'b1, 1'b0, 32'h48, 32'h0, d, st, mw, err);
    tests++;
    if (st !== 0 || d !== 32'hDEADBEEF) begin
      failed++;
      $display("FAIL read_after_write: stall %0d data %h exp 0 deadbeef", st, d);
    end
    cpu_op(1'b1, 1'b0, 32'h440, 32'h0, d, st, mw, err);
    tests++;
    if (st !== MW + 1 || d !== 32'h200 || err) begin
      failed++;
      $display("FAIL replace_0x440: stall %0d data %h exp 5 200", st, d);
    end
    cpu_op(1'b1, 1'b0, 32'h40, 32'h0, d, st, mw, err);
    tests++;
    if (st !== MW + 1 || d !== 32'h100) begin
      failed++;
      $display("FAIL reread_0x40: stall %0d data %h exp 5 100", st, d);
    end
    exp_hit = 2;
    exp_miss = 3;
    mvalid[1] = 1'b1;
    mblk[1] = 32'h40;
    tests++;
    if (hit_count !== (STATS ? exp_hit : 0) || miss_count !== (STATS ? exp_miss : 0)) begin
      failed++;
      $display("FAIL directed_counts: hit %0d miss %0d", hit_count, miss_count);
    end
  endtask

  task automatic test_both_high();
    logic [31:0] d;
    int st;
    int mw;
    bit err;
    cpu_op(1'b1, 1'b1, 32'h4C, 32'hCAFE0001, d, st, mw, err);
    tests++;
    if (mw !== MW || st !== MW || err || hit_count !== (STATS ? exp_hit : 0)) begin
      failed++;
      $display("FAIL both_high_write: mw %0d stall %0d err %b hit %0d", mw, st, err, hit_count);
    end
    cpu_op(1'b1, 1'b0, 32'h4C, 32'h0, d, st, mw, err);
    exp_hit++;
    tests++;
    if (st !== 0 || d !== 32'hCAFE0001) begin
      failed++;
      $display("FAIL both_high_read: stall %0d data %h exp 0 cafe0001", st, d);
    end
  endtask

  task automatic test_reset_fill();
    logic [31:0] d;
    int st;
    int mw;
    bit err;
    cpu_read = 1'b1;
    cpu_address = 32'h84;
    repeat (3) @(negedge clk);
    tests++;
    if (mem_address !== 32'h80) begin
      failed++;
      $display("FAIL fill_address: got %h exp 00000080", mem_address);
    end
    #2;
    reset_n = 1'b0;
    #1;
    tests++;
    if (mem_write !== 1'b0 || mem_address !== 32'h84 || cpu_ready !== 1'b0) begin
      failed++;
      $display("FAIL reset_mid_fill: mw %b addr %h ready %b exp 0 84 0", mem_write, mem_address, cpu_ready);
    end
    cpu_read = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    cpu_op(1'b1, 1'b0, 32'h84, 32'h0, d, st, mw, err);
    tests++;
    if (st !== MW + 1 || d !== mem_rd(32'h84) || err) begin
      failed++;
      $display("FAIL read_after_fill_reset: stall %0d data %h exp 5 %h", st, d, mem_rd(32'h84));
    end
    exp_miss++;
    mvalid[2] = 1'b1;
    mblk[2] = 32'h80;
  endtask

  task automatic test_reset_write();
    logic [31:0] d;
    int st;
    int mw;
    bit err;
    cpu_write = 1'b1;
    cpu_address = 32'h88;
    cpu_write_data = $urandom;
    repeat (3) @(negedge clk);
    tests++;
    if (mem_write !== 1'b1) begin
      failed++;
      $display("FAIL write_strobe: got %b exp 1", mem_write);
    end
    #2;
    reset_n = 1'b0;
    #1;
    tests++;
    if (mem_write !== 1'b0 || hit_count !== 32'd0 || miss_count !== 32'd0) begin
      failed++;
      $display("FAIL reset_mid_write: mw %b hit %0d miss %0d exp 0 0 0", mem_write, hit_count, miss_count);
    end
    cpu_write = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    cpu_op(1'b1, 1'b0, 32'h84, 32'h0, d, st, mw, err);
    tests++;
    if (st !== MW + 1 || d !== mem_rd(32'h84)) begin
      failed++;
      $display("FAIL read_after_write_reset: stall %0d data %h exp 5 %h", st, d, mem_rd(32'h84));
    end
    exp_miss++;
    mvalid[2] = 1'b1;
    mblk[2] = 32'h80;
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] d;
    logic [31:0] exp_d;
    logic [31:0] blk;
    int st;
    int mw;
    int idx;
    int kind;
    bit err;
    bit mhit;
    for (int n = 0; n < 150; n++) begin
      idx = $urandom_range(0, 15);
      a = (32'($urandom_range(0, 3)) << 10) | (32'(idx) << 6) | (32'($urandom_range(0, 15)) << 2);
      wd = $urandom;
      kind = $urandom_range(0, 9);
      blk = {a[31:6], 6'b0};
      if (kind < 4) begin
        cpu_op(kind == 0, 1'b1, a, wd, d, st, mw, err);
        tests++;
        if (mw !== MW || st !== MW || err || mem_rd(a) !== wd) begin
          failed++;
          $display("FAIL rand_write %h: mw %0d stall %0d err %b mem %h exp %h", a, mw, st, err, mem_rd(a), wd);
        end
      end else begin
        mhit = mvalid[idx] && mblk[idx] == blk;
        exp_d = mem_rd(a);
        cpu_op(1'b1, 1'b0, a, wd, d, st, mw, err);
        if (mhit) begin
          exp_hit++;
        end else begin
          exp_miss++;
          mvalid[idx] = 1'b1;
          mblk[idx] = blk;
        end
        tests++;
        if (d !== exp_d || st !== (mhit ? 0 : MW + 1) || mw !== 0 || err) begin
          failed++;
          $display("FAIL rand_read %h: data %h stall %0d mw %0d err %b exp %h %0d", a, d, st, mw, err, exp_d, mhit ? 0 : MW + 1);
        end
        tests++;
        if (hit_count !== (STATS ? exp_hit : 0) || miss_count !== (STATS ? exp_miss : 0)) begin
          failed++;
          $display("FAIL rand_counts: hit %0d miss %0d exp %0d %0d", hit_count, miss_count, STATS ? exp_hit : 0, STATS ? exp_miss : 0);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    test_reset();
    test_directed();
    test_both_high();
    test_reset_fill();
    test_reset_write();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/dcache_ctrl.md
DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 Parameter INDEX_BITS, default 4, SHALL set line count to 2^INDEX_BITS (16 lines of 16 words).
REQ-002 Parameter MEM_WAIT, default 4, range 1..15, SHALL set memory access time in clk cycles.
REQ-003 clk  input  1  sole clock; all state updates on posedge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 cpu_read  input  1  CPU load request, held stable until cpu_ready.
REQ-006 cpu_write  input  1  CPU store request, held stable until cpu_ready.
REQ-007 cpu_address  input  32  byte address; [5:2] word offset, [6+INDEX_BITS-1:6] index, remainder tag.
REQ-008 cpu_write_data  input  32  store data.
REQ-009 cpu_read_data  output  32  load data, valid when cpu_ready and cpu_read.
REQ-010 cpu_ready  output  1  request completes this cycle; low means CPU stalls.
REQ-011 mem_write  output  1  write strobe to data memory.
REQ-012 mem_address  output  32  word address to data memory.
REQ-013 mem_write_data  output  32  store data to data memory.
REQ-014 mem_block_data  input  512  16-word block from data memory, word k at bits [32k+31:32k].
REQ-015 hit_count, miss_count  output  32 each  statistics counters (see Configuration).

Function
REQ-016 Organisation: direct-mapped, write-through, no-write-allocate; per line one valid bit, tag, 16 data words.
REQ-017 States: IDLE, FILL, WRITE.
REQ-018 IDLE, cpu_read, hit: cpu_ready=1 same cycle, cpu_read_data = cached word (combinational), state stays IDLE.
REQ-019 IDLE, cpu_read, miss: cpu_ready=0, go to FILL, load wait counter with MEM_WAIT-1.
REQ-020 FILL: mem_address = {cpu_address[31:6],6'b0}, mem_write=0; counter decrements each cycle; at counter 0 capture mem_block_data into line, write tag, set valid, return to IDLE; access then hits next cycle (miss latency MEM_WAIT+1 cycles).
REQ-021 IDLE, cpu_write: go to WRITE, cpu_ready=0; if hit, update cached word at same edge.
REQ-022 WRITE: mem_write=1, mem_address=cpu_address, mem_write_data=cpu_write_data held for MEM_WAIT cycles; cpu_ready=1 on final cycle; next state IDLE with mem_write=0.
REQ-023 cpu_read and cpu_write both high: treated as write; read ignored.
REQ-024 Neither request: cpu_ready=1, mem_write=0, no state change.
REQ-025 Outside FILL/WRITE, mem_address SHALL equal cpu_address and mem_write SHALL be 0.
REQ-026 Index wrap: a fill to an occupied index SHALL overwrite tag and data (no writeback).

Reset
REQ-027 reset_n low, any state: state=IDLE, all valid bits=0, wait counter=0, hit_count=miss_count=0, mem_write=0 immediately (asynchronous).
REQ-028 Reset mid-FILL SHALL leave the line invalid; mid-WRITE SHALL drop mem_write at once.
REQ-029 Cached data words and tags need no reset.

Configuration
REQ-030 Macro DCACHE_STATS_EN defined: hit_count increments per IDLE read-hit completion, miss_count per read-miss FILL entry, both wrap at 2^32; writes not counted.
REQ-031 DCACHE_STATS_EN undefined: no counter registers, hit_count and miss_count tied to 0.

Verification
REQ-032 After reset, read 0x0000_0040 (block words preloaded 0x100..0x10F) -> cpu_ready low 5 cycles, then data 0x100, miss_count=1.
REQ-033 Then read 0x0000_0044 -> cpu_ready=1 same cycle, data 0x101, hit_count=1.
REQ-034 Write 0xDEADBEEF to 0x0000_0048 (hit) -> mem_write high 4 cycles, ready on 4th; later read 0x48 hits, returns 0xDEADBEEF.
REQ-035 Read 0x0000_0440 (same index 1, new tag) -> miss, line replaced; re-read 0x40 -> misses again.
REQ-036 Assert reset_n low during FILL -> mem_write=0, state IDLE; subsequent read of same address misses.
REQ-037 Build without DCACHE_STATS_EN, repeat REQ-032 -> hit_count=miss_count=0.
